// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch/issue stage and its decoder
// (control_unit): opcode encodings, instruction field bit positions and the
// fetch FSM state type.
// -----------------------------------------------------------------------------
package fetch_pkg;

    // Instruction format: [15:14] opcode, [13:11] rd, [10:8] rs, [7:0] imm
    localparam int OPC_HI = 15;
    localparam int OPC_LO = 14;
    localparam int RD_HI  = 13;
    localparam int RD_LO  = 11;
    localparam int RS_HI  = 10;
    localparam int RS_LO  = 8;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    localparam logic [1:0] OP_MOV = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_RSV = 2'b10;
    localparam logic [1:0] OP_J   = 2'b11;

    typedef enum logic [2:0] {
        ST_HALT   = 3'd0,
        ST_FILL   = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_WAIT_J = 3'd3,
        ST_ERR    = 3'd4
    } fetch_state_t;

    function automatic logic op_is_legal(input logic [1:0] op);
        return (op != OP_RSV);
    endfunction

endpackage

// File: rtl/fetch_unit_prog_mem.sv
// -----------------------------------------------------------------------------
// prog_mem
// Program memory: 2^ADDR_W words of DATA_W bits, one write port and one
// synchronous read port. No reset, so contents survive a fetch_unit reset.
//
// Ports
//   i_clk    clock
//   i_we     write strobe
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address, sampled on the rising edge
//   o_rdata  registered read data
// -----------------------------------------------------------------------------
module prog_mem #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch/issue stage. Holds the PC and a program memory that is
// loaded while halted, presents one instruction per cycle to decode over a
// valid/ready handshake, and stalls after a jump until decode returns the
// jump target.
//
// State table
//   state   | meaning
//   HALT    | idle; program memory writable; wait for run
//   FILL    | memory read of pc in flight
//   ISSUE   | read data presented as instruction fields
//   WAIT_J  | jump issued; wait for pc_src / jump_target
//   ERR     | reserved opcode fetched; left only by reset
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   run                   fetch enable; 0 halts at next instruction boundary
//   prog_we/addr/data     program write port, honoured only in HALT
//   pc_src, jump_target   jump resolution, honoured only in WAIT_J
//   out_valid, out_ready  issue handshake
//   opcode, rd, rs, imm   instruction fields (0 when not issuing)
//   out_pc                address of presented instruction (0 when not issuing)
//   halted                state is HALT
//   illegal               sticky reserved-opcode flag
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               pc_src,
    input  logic [ADDR_W-1:0]  jump_target,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         opcode,
    output logic [2:0]         rd,
    output logic [2:0]         rs,
    output logic [7:0]         imm,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               halted,
    output logic               illegal
);

    fetch_state_t       r_state;
    fetch_state_t       w_state_nxt;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  w_pc_nxt;
    logic [ADDR_W-1:0]  w_pc_inc;
    logic [ADDR_W-1:0]  w_rd_addr;
    logic [INSTR_W-1:0] w_rd_data;
    logic               r_illegal;
    logic               w_illegal_nxt;
    logic               w_issue;
    logic               w_valid;
    logic               w_accept;
    logic               w_mem_we;
    logic [1:0]         w_op;

    // Memory read address follows the PC; on an accepted transfer the next
    // word is fetched one cycle early so back-to-back issue has no bubble.
    // Re-reading pc while stalled keeps the fields stable because the memory
    // cannot be written outside HALT.
    always_comb begin
        w_issue   = (r_state == ST_ISSUE);
        w_op      = w_rd_data[OPC_HI:OPC_LO];
        w_valid   = w_issue && op_is_legal(w_op);
        w_accept  = w_valid && out_ready;
        w_mem_we  = prog_we && (r_state == ST_HALT);
        w_pc_inc  = r_pc + ADDR_W'(1);
        w_rd_addr = w_accept ? w_pc_inc : r_pc;
    end

    prog_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (INSTR_W)
    ) u_prog_mem (
        .i_clk   (clk),
        .i_we    (w_mem_we),
        .i_waddr (prog_addr),
        .i_wdata (prog_data),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_HALT;
            r_pc      <= RESET_PC;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_illegal <= w_illegal_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_illegal_nxt = r_illegal;
        case (r_state)
            ST_HALT: begin
                if (run) begin
                    w_state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                w_state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (!op_is_legal(w_op)) begin
                    w_state_nxt   = ST_ERR;
                    w_illegal_nxt = 1'b1;
                end else if (w_accept) begin
                    w_pc_nxt = w_pc_inc;
                    if (w_op == OP_J) begin
                        w_state_nxt = ST_WAIT_J;
                    end else if (!run) begin
                        w_state_nxt = ST_HALT;
                    end
                end
            end
            ST_WAIT_J: begin
                if (pc_src) begin
                    w_pc_nxt    = jump_target;
                    w_state_nxt = run ? ST_FILL : ST_HALT;
                end
            end
            ST_ERR: begin
                w_illegal_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = ST_HALT;
            end
        endcase
    end

    // Fields are forced to zero outside ISSUE so that reset/halt present a
    // clean, known bus to decode regardless of the memory read register.
    always_comb begin
        out_valid = w_valid;
        opcode    = '0;
        rd        = '0;
        rs        = '0;
        imm       = '0;
        out_pc    = '0;
        if (w_issue) begin
            opcode = w_op;
            rd     = w_rd_data[RD_HI:RD_LO];
            rs     = w_rd_data[RS_HI:RS_LO];
            imm    = w_rd_data[IMM_HI:IMM_LO];
            out_pc = r_pc;
        end
        halted  = (r_state == ST_HALT);
        illegal = r_illegal;
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        prog_we = 1'b0;
    logic [7:0]  prog_addr = '0;
    logic [15:0] prog_data = '0;
    logic        pc_src = 1'b0;
    logic [7:0]  jump_target = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [1:0]  opcode;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [7:0]  imm;
    logic [7:0]  out_pc;
    logic        halted;
    logic        illegal;
    logic [15:0] w_word;

    int total = 0;
    int bad = 0;

    // Reference program image: what decode must see at each address.
    logic [15:0] mm [256];

    fetch_unit #(
        .ADDR_W   (8),
        .INSTR_W  (16),
        .RESET_PC (8'h00)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .pc_src      (pc_src),
        .jump_target (jump_target),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .opcode      (opcode),
        .rd          (rd),
        .rs          (rs),
        .imm         (imm),
        .out_pc      (out_pc),
        .halted      (halted),
        .illegal     (illegal)
    );

    assign w_word = {opcode, rd, rs, imm};

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_instr(input string tag, input logic [7:0] pc);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_pc"}, 32'(out_pc), 32'(pc));
        chk({tag, "_word"}, 32'(w_word), 32'(mm[pc]));
    endtask

    task automatic load(input logic [7:0] a, input logic [15:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        cycle();
        prog_we   = 1'b0;
        mm[a]     = d;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        run       = 1'b0;
        out_ready = 1'b0;
        pc_src    = 1'b0;
        prog_we   = 1'b0;
        #2;
        chk("rst_halted", 32'(halted), 32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_word", 32'(w_word), 32'd0);
        chk("rst_pc", 32'(out_pc), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
    endtask

    function automatic logic [15:0] alu_word(input logic sll);
        return {1'b0, sll, 14'($urandom)};
    endfunction

    function automatic logic [15:0] legal_word();
        if ($urandom_range(0, 7) == 0) return {2'b11, 14'($urandom)};
        return alu_word(1'($urandom_range(0, 1)));
    endfunction

    initial begin
        logic [7:0]  exp_pc;
        logic [15:0] cur;
        bit          jw;
        int          fl;
        bit          expv;

        do_reset();

        for (int a = 0; a < 256; a++) load(8'(a), legal_word());
        for (int a = 0; a < 4; a++) load(8'(a), alu_word(1'(a % 2)));

        // Straight-line stream 0..3, halting after the last one
        run = 1'b1;
        out_ready = 1'b1;
        cycle();
        chk("t1_fill_valid", 32'(out_valid), 32'd0);
        chk("t1_fill_halted", 32'(halted), 32'd0);
        cycle();
        for (int i = 0; i < 4; i++) begin
            chk_instr("t1", 8'(i));
            if (i == 3) run = 1'b0;
            cycle();
        end
        chk("t1_halted", 32'(halted), 32'd1);
        chk("t1_end_valid", 32'(out_valid), 32'd0);

        // Backpressure on PC 1
        do_reset();
        run = 1'b1;
        out_ready = 1'b1;
        cycle();
        cycle();
        chk_instr("t2_first", 8'd0);
        cycle();
        chk_instr("t2_stall", 8'd1);
        out_ready = 1'b0;
        for (int h = 0; h < 3; h++) begin
            cycle();
            chk_instr("t2_hold", 8'd1);
        end
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            chk_instr("t2_resume", 8'(i));
            if (i == 3) run = 1'b0;
            cycle();
        end
        chk("t2_halted", 32'(halted), 32'd1);

        // run dropped while stalled: pending instruction still transferred
        do_reset();
        run = 1'b1;
        cycle();
        cycle();
        chk_instr("t3_pend", 8'd0);
        run = 1'b0;
        for (int h = 0; h < 3; h++) begin
            cycle();
            chk_instr("t3_held", 8'd0);
            chk("t3_not_halted", 32'(halted), 32'd0);
        end
        out_ready = 1'b1;
        cycle();
        chk("t3_halted", 32'(halted), 32'd1);
        chk("t3_valid", 32'(out_valid), 32'd0);
        run = 1'b1;
        out_ready = 1'b0;
        cycle();
        cycle();
        chk_instr("t3_next", 8'd1);
        run = 1'b0;
        out_ready = 1'b1;
        cycle();
        chk("t3_halted2", 32'(halted), 32'd1);

        // Jump handling, ignored pc_src in ISSUE, and PC wrap
        load(8'h02, 16'hC000);
        load(8'h10, 16'hC000);
        load(8'hFF, alu_word(1'b0));
        do_reset();
        run = 1'b1;
        out_ready = 1'b1;
        cycle();
        cycle();
        chk_instr("t4_pc0", 8'd0);
        pc_src = 1'b1;
        jump_target = 8'h33;
        cycle();
        chk_instr("t4_pc1", 8'd1);
        cycle();
        pc_src = 1'b0;
        chk_instr("t4_jmp", 8'd2);
        cycle();
        for (int w = 0; w < 4; w++) begin
            chk("t4_wait_valid", 32'(out_valid), 32'd0);
            if (w == 3) begin
                pc_src = 1'b1;
                jump_target = 8'h10;
            end
            cycle();
        end
        pc_src = 1'b0;
        chk("t4_fill_valid", 32'(out_valid), 32'd0);
        cycle();
        chk_instr("t4_target", 8'h10);
        cycle();
        chk("t4_wait2_valid", 32'(out_valid), 32'd0);
        pc_src = 1'b1;
        jump_target = 8'hFF;
        cycle();
        pc_src = 1'b0;
        chk("t4_fill2_valid", 32'(out_valid), 32'd0);
        cycle();
        chk_instr("t4_ff", 8'hFF);
        cycle();
        chk_instr("t4_wrap", 8'h00);
        run = 1'b0;
        cycle();
        chk("t4_halted", 32'(halted), 32'd1);

        // Randomized run against the program-order model; writes while
        // running must never reach memory.
        do_reset();
        run = 1'b1;
        out_ready = 1'b1;
        exp_pc = 8'h00;
        jw = 1'b0;
        fl = 1;
        for (int n = 0; n < 600; n++) begin
            cycle();
            expv = !jw && (fl == 0);
            chk("rnd_valid", 32'(out_valid), 32'(expv));
            if (expv && out_valid) begin
                chk("rnd_pc", 32'(out_pc), 32'(exp_pc));
                chk("rnd_word", 32'(w_word), 32'(mm[exp_pc]));
            end
            if (fl > 0) fl--;
            out_ready = ($urandom_range(0, 3) != 0);
            pc_src    = 1'b0;
            prog_we   = ($urandom_range(0, 7) == 0);
            prog_addr = 8'($urandom);
            prog_data = 16'($urandom);
            if (expv && out_ready) begin
                cur = mm[exp_pc];
                if (cur[15:14] == 2'b11) jw = 1'b1;
                else exp_pc = exp_pc + 8'd1;
            end else if (jw) begin
                if ($urandom_range(0, 2) == 0) begin
                    pc_src = 1'b1;
                    jump_target = 8'($urandom);
                    exp_pc = jump_target;
                    jw = 1'b0;
                    fl = 1;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                pc_src = 1'b1;
                jump_target = 8'($urandom);
            end
        end
        prog_we = 1'b0;
        pc_src = 1'b0;

        // Reserved opcode at PC 5, then recovery by reset
        for (int a = 0; a < 5; a++) load(8'(a), alu_word(1'($urandom_range(0, 1))));
        do_reset();
        for (int a = 0; a < 5; a++) load(8'(a), alu_word(1'($urandom_range(0, 1))));
        load(8'h05, 16'h8000);
        run = 1'b1;
        out_ready = 1'b1;
        cycle();
        cycle();
        for (int i = 0; i < 5; i++) begin
            chk_instr("t6", 8'(i));
            cycle();
        end
        chk("t6_rsv_valid", 32'(out_valid), 32'd0);
        cycle();
        for (int h = 0; h < 4; h++) begin
            chk("t6_err_valid", 32'(out_valid), 32'd0);
            chk("t6_err_illegal", 32'(illegal), 32'd1);
            chk("t6_err_halted", 32'(halted), 32'd0);
            cycle();
        end
        do_reset();
        chk("t6_post_halted", 32'(halted), 32'd1);
        chk("t6_post_illegal", 32'(illegal), 32'd0);
        run = 1'b1;
        out_ready = 1'b1;
        cycle();
        cycle();
        chk_instr("t6_after", 8'd0);
        run = 1'b0;
        cycle();
        chk("t6_halted", 32'(halted), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch/issue stage that produces the 2-bit opcode and operand fields consumed by `control_unit`, and closes the loop on its `PCsrc` jump request. Holds the program counter and an internal synchronous-read program memory loaded while halted. Issues one instruction per cycle to decode over a valid/ready handshake. Stalls after a jump until decode/execute returns the jump target.

## Interface
- `ADDR_W`, 8: program counter / memory address width; memory depth is 2^ADDR_W
- `INSTR_W`, 16: instruction width; fixed format [15:14] opcode, [13:11] rd, [10:8] rs, [7:0] imm
- `RESET_PC`, 0: PC value loaded on reset
- `clk`  in  1  single clock; all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `run`  in  1  1 = fetch enabled; 0 = halt at the next instruction boundary
- `prog_we`  in  1  program-memory write strobe, honoured only in HALT
- `prog_addr`  in  ADDR_W  program write address
- `prog_data`  in  INSTR_W  program write data
- `pc_src`  in  1  jump taken (decode `PCsrc`), honoured only in WAIT_J
- `jump_target`  in  ADDR_W  PC to load when `pc_src`=1
- `out_valid`  out  1  instruction fields valid
- `out_ready`  in  1  decode accepts; transfer when `out_valid & out_ready`
- `opcode`  out  2  instruction [15:14]
- `rd`, `rs`  out  3 each  register fields
- `imm`  out  8  immediate field
- `out_pc`  out  ADDR_W  address of the presented instruction
- `halted`  out  1  state is HALT
- `illegal`  out  1  sticky; reserved opcode 2'b10 fetched

## Operation
- Opcodes: 00 MOV, 01 SLL, 11 J, 10 reserved (illegal).
- States: HALT, FILL, ISSUE, WAIT_J, ERR.
- HALT: `prog_we` writes memory; `run`=1 -> FILL. Writes in other states are dropped.
- FILL: memory read address = `pc`; -> ISSUE.
- ISSUE: fields driven directly from memory read data; `out_valid`=1 unless opcode is 10.
  - Read address = `pc+1` on accept, else `pc`. Fields are stable while stalled.
  - Accept: `pc <= pc+1`, wrapping 2^ADDR_W-1 -> 0.
  - Accepted J -> WAIT_J. Accepted non-J with `run`=0 -> HALT.
  - With `run`=0 and no transfer, the presented instruction stays valid until accepted.
  - Fetched opcode 10: `out_valid`=0, -> ERR, `illegal` set.
- WAIT_J: `out_valid`=0; `pc_src`=1 loads `pc <= jump_target`, then -> FILL (or -> HALT if `run`=0 that cycle). Without `pc_src`, stays indefinitely.
- ERR: `out_valid`=0, `illegal`=1; left only by reset.
- Reset, including mid-operation: state HALT, `pc`=RESET_PC, `out_valid`=0, `illegal`=0, `halted`=1, and all field outputs 0. Memory contents are preserved.

## Timing
- `run` sampled high in HALT at edge k: FILL during cycle k, `out_valid`=1 from cycle k+1.
- With `out_ready` held high, throughput is one instruction per cycle; `out_pc` increments by 1 each cycle.
- J accepted at edge k: `out_valid`=0 from cycle k. `pc_src` sampled at edge m: FILL in cycle m, target instruction valid in cycle m+1.
- Memory write at edge k is readable by a FILL starting at edge k+1.
- `pc_src` in any state other than WAIT_J is ignored.

## Structure
- Shared package `fetch_pkg`:
  - opcode constants OP_MOV, OP_SLL, OP_RSV, OP_J
  - state enum
  - field bit-position constants shared with `control_unit`
- Sub-module `prog_mem`: depth 2^ADDR_W × INSTR_W, one write port, one synchronous read port, no reset.
- `fetch_unit` holds the FSM, PC and address mux.

## Test plan
- Load 0x0000..0x0003 = MOV, SLL, MOV, SLL; run=1, ready=1 -> four transfers on consecutive cycles, `out_pc` 0,1,2,3; first valid 2 cycles after run.
- Backpressure: ready low 3 cycles on instruction at PC 1 -> fields and `out_pc`=1 held constant; no skip and no duplicate after ready returns.
- J at PC 2 (0xC000), `pc_src`=1 with target 0x10 after 4 cycles -> `out_valid` low 5 cycles, then `out_pc`=0x10; `pc_src` pulses while in ISSUE are ignored.
- PC wrap: instruction at 0xFF with ready=1 -> next `out_pc`=0x00.
- Reserved word 0x8000 at PC 5 -> `out_valid` never asserts for it; `illegal`=1 and stays 1 until reset; `rst_n` pulse -> HALT, `pc`=0, memory intact.
- `run` dropped while stalled -> pending instruction still transferred, then `halted`=1; `prog_we` while running leaves memory unchanged.
